multi_mode_ff_bank: RTL and testbench

- Parametrised bank of WIDTH flip-flops; one run-time mode selects how the whole bank updates: D, T, JK, or up/down counter.
- Successor to the single-bit gate-level toggle flip-flop. Adds:
  - vector width,
  - selectable modes,
  - a clock enable,
  - a synchronous clear distinct from the asynchronous reset,
  - per-bit change flags,
  - a counter wrap pulse.
- Used as the general state-holding primitive for lab datapaths, including counters, toggling LED banks and JK exercises.

---
 rtl/multi_mode_ff_bank.sv | 64 ++++++
 tb/tb_multi_mode_ff_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops updated as D, T, JK or up/down counter, selected per edge by mode.
// Also provides a sync clear, clock enable, per-bit change flags and a counter wrap pulse.
module multi_mode_ff_bank #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] changed,
  output logic             wrap
);

  localparam logic [1:0] MODE_D   = 2'b00;
  localparam logic [1:0] MODE_T   = 2'b01;
  localparam logic [1:0] MODE_JK  = 2'b10;
  localparam logic [1:0] MODE_CNT = 2'b11;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Next-state selection: sclr beats en, en beats mode.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (sclr) begin
      q_next = RST_VAL;
    end else if (en) begin
      case (mode)
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        MODE_JK: q_next = (a & ~q) | (~b & q);
        MODE_CNT: begin
          if (a[0]) begin
            q_next    = q - WIDTH'(1);
            wrap_next = ~|q;
          end else begin
            q_next    = q + WIDTH'(1);
            wrap_next = &q;
          end
        end
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RST_VAL;
      changed <= '0;
      wrap    <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= q_next ^ q;
      wrap    <= wrap_next;
    end
  end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Scoreboard bench for multi_mode_ff_bank: directed scenarios plus random traffic
// against a per-mode behavioural model.
module tb_multi_mode_ff_bank;

  localparam int unsigned WIDTH   = 8;
  localparam logic [7:0]  RST_VAL = 8'hA5;

  typedef struct {
    logic [7:0] q;
    logic [7:0] ch;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclr, en;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [7:0] q, changed;
  logic       wrap;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [7:0] m_q;

  multi_mode_ff_bank #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .en(en), .mode(mode),
    .a(a), .b(b), .q(q), .changed(changed), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each mode evaluated from its textbook definition.
  task automatic issue(input logic s, input logic e, input logic [1:0] md,
                       input logic [7:0] av, input logic [7:0] bv);
    exp_t x;
    int unsigned nxt;
    sclr = s; en = e; mode = md; a = av; b = bv;
    x.w = 1'b0;
    x.q = m_q;
    if (s) x.q = RST_VAL;
    else if (e) begin
      case (md)
        2'd0: x.q = av;
        2'd1: for (int i = 0; i < 8; i++) x.q[i] = av[i] ? ~m_q[i] : m_q[i];
        2'd2: for (int i = 0; i < 8; i++)
                case ({av[i], bv[i]})
                  2'b11:   x.q[i] = ~m_q[i];
                  2'b10:   x.q[i] = 1'b1;
                  2'b01:   x.q[i] = 1'b0;
                  default: x.q[i] = m_q[i];
                endcase
        default: begin
          if (av[0]) nxt = (int'(m_q) + 255) % 256;
          else       nxt = (int'(m_q) + 1) % 256;
          x.q = 8'(nxt);
          x.w = av[0] ? (nxt > int'(m_q)) : (nxt < int'(m_q));
        end
      endcase
    end
    x.ch = x.q ^ m_q;
    m_q = x.q;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic s, input logic e, input logic [1:0] md,
                      input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    issue(s, e, md, av, bv);
  endtask

  // Monitor: outputs are live every edge out of reset.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (!rst && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("q", 32'(q), 32'(x.q));
      chk("changed", 32'(changed), 32'(x.ch));
      chk("wrap", 32'(wrap), 32'(x.w));
    end
  end

  initial begin
    rst = 1'b1; sclr = 1'b0; en = 1'b0; mode = 2'd0; a = '0; b = '0;
    m_q = RST_VAL;
    #7;
    chk("reset_q", 32'(q), 32'(RST_VAL));
    chk("reset_changed", 32'(changed), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // T then hold
    step(0, 1, 2'd0, 8'h00, 8'h00);
    repeat (3) step(0, 1, 2'd1, 8'h0F, 8'h00);
    repeat (2) step(0, 0, 2'd1, 8'h0F, 8'h00);
    step(0, 1, 2'd1, 8'h00, 8'h00);

    // JK truth table
    step(0, 1, 2'd0, 8'hCC, 8'h00);
    repeat (2) step(0, 1, 2'd2, 8'hAA, 8'h66);

    // Counter wrap both directions
    step(0, 1, 2'd0, 8'hFE, 8'h00);
    repeat (3) step(0, 1, 2'd3, 8'h00, 8'h5A);
    repeat (2) step(0, 1, 2'd3, 8'hF1, 8'h00);

    // Priority of sclr
    step(0, 1, 2'd0, 8'hFF, 8'h00);
    step(1, 1, 2'd3, 8'h00, 8'h00);
    step(0, 1, 2'd0, 8'hFF, 8'h00);
    step(1, 0, 2'd3, 8'h00, 8'h00);

    // Mode switch each cycle
    step(0, 1, 2'd0, 8'h00, 8'h00);
    step(0, 1, 2'd0, 8'h81, 8'h00);
    step(0, 1, 2'd1, 8'h01, 8'h00);
    step(0, 1, 2'd3, 8'h00, 8'h00);

    // Async reset pulsed mid-cycle
    @(negedge clk);
    en = 1'b1; mode = 2'd0; a = 8'h3C; sclr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_q", 32'(q), 32'(RST_VAL));
    chk("async_changed", 32'(changed), 32'h0);
    chk("async_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_q = RST_VAL;
    issue(0, 1, 2'd0, 8'h3C, 8'h00);

    // Random traffic
    for (int n = 0; n < 400; n++)
      step(($urandom_range(15) == 0), ($urandom_range(7) != 0),
           2'($urandom_range(3)), 8'($urandom), 8'($urandom));

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
